// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured MSB-first pattern reps+1 times,
// optionally separated by GAP idle cycles, with abort and one-cycle done pulse.
module seq_pattern_tx #(
    parameter int   WIDTH      = 16,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             pattern,
    input  logic [$clog2(WIDTH+1)-1:0]   len,
    input  logic [3:0]                   reps,
    input  logic                         abort,
    output logic                         x,
    output logic                         bit_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int             LW       = $clog2(WIDTH+1);
    localparam logic [LW-1:0]  LEN_MAX  = LW'(WIDTH);
    localparam logic [7:0]     GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t          state_reg;
    logic [WIDTH-1:0] pat_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [LW-1:0]    len_reg;
    logic [LW-1:0]    bit_cnt_reg;
    logic [3:0]       rep_cnt_reg;
    logic [7:0]       gap_cnt_reg;

    logic [LW-1:0]    len_eff;
    logic [WIDTH-1:0] aligned;

    // The pattern is left-aligned on capture so every bit leaves from the MSB.
    always_comb begin
        len_eff = (len > LEN_MAX) ? LEN_MAX : len;
        aligned = pattern << (LEN_MAX - len_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            x           <= IDLE_LEVEL;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pat_reg     <= '0;
            shift_reg   <= '0;
            len_reg     <= '0;
            bit_cnt_reg <= '0;
            rep_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start && len_eff != '0) begin
                        state_reg   <= ST_SHIFT;
                        pat_reg     <= aligned;
                        shift_reg   <= aligned << 1;
                        len_reg     <= len_eff;
                        bit_cnt_reg <= len_eff - 1'b1;
                        rep_cnt_reg <= reps;
                        x           <= aligned[WIDTH-1];
                        bit_valid   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        x         <= IDLE_LEVEL;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (bit_cnt_reg != '0) begin
                        x           <= shift_reg[WIDTH-1];
                        shift_reg   <= shift_reg << 1;
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                    end else if (rep_cnt_reg != 4'd0) begin
                        rep_cnt_reg <= rep_cnt_reg - 4'd1;
                        if (GAP > 0) begin
                            state_reg   <= ST_GAP;
                            gap_cnt_reg <= GAP_LOAD;
                            x           <= IDLE_LEVEL;
                            bit_valid   <= 1'b0;
                        end else begin
                            x           <= pat_reg[WIDTH-1];
                            shift_reg   <= pat_reg << 1;
                            bit_cnt_reg <= len_reg - 1'b1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                        x         <= IDLE_LEVEL;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        x         <= IDLE_LEVEL;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (gap_cnt_reg == 8'd0) begin
                        state_reg   <= ST_SHIFT;
                        x           <= pat_reg[WIDTH-1];
                        shift_reg   <= pat_reg << 1;
                        bit_cnt_reg <= len_reg - 1'b1;
                        bit_valid   <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=0, one with GAP=3,
// driven by shared stimulus; each scenario checks recorded output streams.
module tb_seq_pattern_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic [3:0]  reps = '0;
    logic        abort = 1'b0;

    logic x0, bv0, busy0, done0;
    logic x3, bv3, busy3, done3;

    int checks = 0;
    int errors = 0;

    logic [63:0] rec_x, rec_bv, rec_busy, rec_done;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(16), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .abort(abort), .x(x0), .bit_valid(bv0), .busy(busy0), .done(done0)
    );

    seq_pattern_tx #(.WIDTH(16), .GAP(3), .IDLE_LEVEL(1'b0)) dut3 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .abort(abort), .x(x3), .bit_valid(bv3), .busy(busy3), .done(done3)
    );

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Records n cycles of the selected instance, oldest cycle in the highest bit.
    task automatic capture(input int n, input bit sel, input int abort_at,
                           input int sa1, input int sa2);
        rec_x = '0; rec_bv = '0; rec_busy = '0; rec_done = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            rec_x    = {rec_x[62:0],    sel ? x3    : x0};
            rec_bv   = {rec_bv[62:0],   sel ? bv3   : bv0};
            rec_busy = {rec_busy[62:0], sel ? busy3 : busy0};
            rec_done = {rec_done[62:0], sel ? done3 : done0};
            if (i == abort_at) abort = 1'b1;
            if (i == sa1 || i == sa2) start = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; pattern = 16'h000B; len = 5'd4; reps = 4'd0;
        @(posedge clk); #1;
        checks++;
        if ({x0, bv0, busy0, done0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dut0 got %b exp 0000", {x0, bv0, busy0, done0});
        end
        checks++;
        if ({x3, bv3, busy3, done3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dut3 got %b exp 0000", {x3, bv3, busy3, done3});
        end
        reset = 1'b0; start = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        pattern = 16'h000B; len = 5'd4; reps = 4'd0; start = 1'b1;
        capture(6, 1'b0, -1, -1, -1);
        checks++;
        if (rec_x !== 64'(6'b101100)) begin
            errors++; $display("FAIL basic_x got %b exp %b", rec_x, 64'(6'b101100));
        end
        checks++;
        if (rec_bv !== 64'(6'b111100)) begin
            errors++; $display("FAIL basic_bv got %b exp %b", rec_bv, 64'(6'b111100));
        end
        checks++;
        if (rec_busy !== 64'(6'b111100)) begin
            errors++; $display("FAIL basic_busy got %b exp %b", rec_busy, 64'(6'b111100));
        end
        checks++;
        if (rec_done !== 64'(6'b000010)) begin
            errors++; $display("FAIL basic_done got %b exp %b", rec_done, 64'(6'b000010));
        end
        $display("test_basic done");
    endtask

    task automatic test_gap0();
        do_reset();
        pattern = 16'b1011011; len = 5'd7; reps = 4'd1; start = 1'b1;
        capture(16, 1'b0, -1, -1, -1);
        checks++;
        if (rec_x !== 64'(16'b1011011_1011011_00)) begin
            errors++; $display("FAIL gap0_x got %b", rec_x);
        end
        checks++;
        if (rec_bv !== 64'(16'b1111111_1111111_00)) begin
            errors++; $display("FAIL gap0_bv got %b", rec_bv);
        end
        checks++;
        if (rec_done !== 64'(16'b0000000_0000000_10)) begin
            errors++; $display("FAIL gap0_done got %b", rec_done);
        end
        $display("test_gap0 done");
    endtask

    task automatic test_gap3();
        do_reset();
        pattern = 16'b1011011; len = 5'd7; reps = 4'd2; start = 1'b1;
        capture(29, 1'b1, -1, -1, -1);
        checks++;
        if (rec_x !== 64'(29'b1011011_000_1011011_000_1011011_00)) begin
            errors++; $display("FAIL gap3_x got %b", rec_x);
        end
        checks++;
        if (rec_bv !== 64'(29'b1111111_000_1111111_000_1111111_00)) begin
            errors++; $display("FAIL gap3_bv got %b", rec_bv);
        end
        checks++;
        if (rec_busy !== 64'(29'b1111111_111_1111111_111_1111111_00)) begin
            errors++; $display("FAIL gap3_busy got %b", rec_busy);
        end
        checks++;
        if (rec_done !== 64'(29'b0000000_000_0000000_000_0000000_10)) begin
            errors++; $display("FAIL gap3_done got %b", rec_done);
        end
        $display("test_gap3 done");
    endtask

    task automatic test_abort();
        do_reset();
        pattern = 16'h00A5; len = 5'd8; reps = 4'd0; start = 1'b1;
        capture(6, 1'b0, 2, -1, -1);
        checks++;
        if (rec_x !== 64'(6'b101000)) begin
            errors++; $display("FAIL abort_x got %b exp %b", rec_x, 64'(6'b101000));
        end
        checks++;
        if (rec_busy !== 64'(6'b111000)) begin
            errors++; $display("FAIL abort_busy got %b exp %b", rec_busy, 64'(6'b111000));
        end
        checks++;
        if (rec_done !== 64'(6'b000000)) begin
            errors++; $display("FAIL abort_done got %b exp 0", rec_done);
        end
        // abort together with start in IDLE: start wins
        do_reset();
        pattern = 16'h000B; len = 5'd4; reps = 4'd0; start = 1'b1; abort = 1'b1;
        capture(2, 1'b0, -1, -1, -1);
        checks++;
        if (rec_bv !== 64'(2'b11) || rec_x !== 64'(2'b10)) begin
            errors++; $display("FAIL abort_idle got bv %b x %b exp bv 11 x 10", rec_bv, rec_x);
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_gap();
        do_reset();
        pattern = 16'b1011011; len = 5'd7; reps = 4'd2; start = 1'b1;
        capture(8, 1'b1, -1, -1, -1);
        checks++;
        if (rec_bv !== 64'(8'b11111110) || rec_busy !== 64'(8'hFF)) begin
            errors++; $display("FAIL rgap_pre got bv %b busy %b", rec_bv, rec_busy);
        end
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++;
        if ({x3, bv3, busy3, done3} !== 4'b0000) begin
            errors++; $display("FAIL rgap_reset got %b exp 0000", {x3, bv3, busy3, done3});
        end
        len = 5'd0; start = 1'b1;
        capture(4, 1'b1, -1, -1, -1);
        checks++;
        if (rec_bv !== 64'd0 || rec_busy !== 64'd0 || rec_done !== 64'd0) begin
            errors++; $display("FAIL len0 got bv %b busy %b done %b exp 0", rec_bv, rec_busy, rec_done);
        end
        pattern = 16'h000B; len = 5'd4; reps = 4'd0; start = 1'b1;
        capture(6, 1'b1, -1, -1, -1);
        checks++;
        if (rec_x !== 64'(6'b101100) || rec_done !== 64'(6'b000010)) begin
            errors++; $display("FAIL rgap_after got x %b done %b exp x 101100 done 000010", rec_x, rec_done);
        end
        $display("test_reset_gap done");
    endtask

    task automatic test_len_clamp();
        do_reset();
        pattern = 16'h8001; len = 5'd20; reps = 4'd0; start = 1'b1;
        capture(18, 1'b0, -1, -1, -1);
        checks++;
        if (rec_x !== 64'(18'b1000000000000001_00)) begin
            errors++; $display("FAIL clamp_x got %b", rec_x);
        end
        checks++;
        if (rec_done !== 64'(18'b0000000000000000_10)) begin
            errors++; $display("FAIL clamp_done got %b", rec_done);
        end
        $display("test_len_clamp done");
    endtask

    task automatic test_reps15();
        do_reset();
        pattern = 16'h0001; len = 5'd1; reps = 4'd15; start = 1'b1;
        capture(18, 1'b0, -1, -1, -1);
        checks++;
        if (rec_bv !== 64'(18'b1111111111111111_00)) begin
            errors++; $display("FAIL reps15_bv got %b", rec_bv);
        end
        checks++;
        if (rec_done !== 64'(18'b0000000000000000_10)) begin
            errors++; $display("FAIL reps15_done got %b", rec_done);
        end
        $display("test_reps15 done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        pattern = 16'h000B; len = 5'd4; reps = 4'd0; start = 1'b1;
        capture(12, 1'b0, -1, 4, 6);
        checks++;
        if (rec_x !== 64'(12'b1011_0_1011_000)) begin
            errors++; $display("FAIL b2b_x got %b", rec_x);
        end
        checks++;
        if (rec_busy !== 64'(12'b1111_0_1111_000)) begin
            errors++; $display("FAIL b2b_busy got %b", rec_busy);
        end
        checks++;
        if (rec_done !== 64'(12'b0000_1_0000_100)) begin
            errors++; $display("FAIL b2b_done got %b", rec_done);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap0();
        test_gap3();
        test_abort();
        test_reset_gap();
        test_len_clamp();
        test_reps15();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
